// File: rtl/apb3_master.sv
// ---------------------------------------------------------------------------
// apb3_master
//   APB3 requester. Takes one command at a time over a valid/ready handshake,
//   runs it as an APB3 SETUP/ACCESS transfer and returns exactly one response
//   pulse per accepted command. Handles PREADY wait states and PSLVERR. A
//   transfer that waits too long in ACCESS is aborted with a timeout response.
//
//   Parameters
//     ADDR_W   address width
//     DATA_W   data width
//     TIMEOUT  consecutive PREADY=0 ACCESS edges that abort (0 = never)
//
//   Ports
//     PCLK, PRESETn          clock, asynchronous active-low reset
//     cmd_valid/cmd_ready    command handshake
//     cmd_write/addr/wdata   command payload (captured on accept)
//     rsp_valid              one-cycle response pulse, no backpressure
//     rsp_rdata/err/timeout  response payload, held until the next response
//     PADDR..PENABLE         APB3 requester outputs
//     PRDATA/PREADY/PSLVERR  APB3 completer inputs
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | cmd_ready=1, bus idle, PADDR/PWDATA/PWRITE hold last values
//   SETUP  | PSEL=1, PENABLE=0, one cycle only
//   ACCESS | PSEL=1, PENABLE=1, waits for PREADY or the timeout
// ---------------------------------------------------------------------------
module apb3_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // A zero TIMEOUT would give a zero-width counter; keep one bit so the
    // register stays legal even though it is never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The abort fires on the edge that would push the count to TIMEOUT,
    // i.e. when the count already equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PWRITE    <= cmd_write;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        // PRDATA/PSLVERR are only looked at on this edge.
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        state       <= IDLE;
                    end else if ((TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_master.sv
// ---------------------------------------------------------------------------
// tb_apb3_master
//   Directed bench for apb3_master (TIMEOUT=16). A schedule model predicts,
//   from each accepted command and its scripted completer behaviour, the
//   edge on which the response must appear; the per-cycle outputs follow
//   from where the current edge lies inside that window. A scripted
//   completer drives PREADY/PRDATA/PSLVERR from the same schedule and
//   drives noise on them whenever they must be ignored.
// ---------------------------------------------------------------------------
module tb_apb3_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;
    localparam int NV = 10;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb3_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;   // PREADY=0 ACCESS edges before PREADY=1
        logic          err;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vec [NV];

    int passed = 0;
    int total  = 0;

    // model state
    int            e = 0;
    int            n_acc = 0;
    bit            in_flight = 0;
    int            acc_edge = 0;
    int            end_edge = 0;
    bit            cur_to = 0;
    vec_t          cur;
    logic          x_rsp_valid = 0;
    logic [DW-1:0] x_rdata = '0;
    logic          x_err = 0;
    logic          x_to = 0;
    logic [AW-1:0] x_paddr = '0;
    logic [DW-1:0] x_pwdata = '0;
    logic          x_pwrite = 0;

    // observations of the DUT
    logic          pre_v = 0;
    logic          pre_r = 0;
    int            dut_acc_e = 0;
    int            dut_acc_cnt = 0;
    int            acc_hist [16];
    int            rsp_cnt = 0;
    int            last_lat = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 0;
    logic          last_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
    endtask

    // schedule model
    initial begin
        bit done;
        forever begin
            @(posedge PCLK or negedge PRESETn);
            if (!PRESETn) begin
                in_flight   = 0;
                x_rsp_valid = 0;
                x_rdata     = '0;
                x_err       = 0;
                x_to        = 0;
                x_paddr     = '0;
                x_pwdata    = '0;
                x_pwrite    = 0;
            end else begin
                e++;
                x_rsp_valid = 0;
                done = 0;
                if (in_flight && e == end_edge) begin
                    in_flight   = 0;
                    done        = 1;
                    x_rsp_valid = 1;
                    x_to        = cur_to;
                    x_err       = cur_to | cur.err;
                    x_rdata     = (cur_to || cur.wr) ? '0 : cur.rdata;
                end
                if (!in_flight && !done && cmd_valid && n_acc < NV) begin
                    cur       = vec[n_acc];
                    n_acc++;
                    in_flight = 1;
                    acc_edge  = e;
                    x_paddr   = cmd_addr;
                    x_pwdata  = cmd_wdata;
                    x_pwrite  = cmd_write;
                    cur_to    = (T != 0) && (cur.waits >= T);
                    end_edge  = cur_to ? e + 1 + T : e + 2 + cur.waits;
                end
            end
        end
    end

    // scripted completer
    initial begin
        bit completing;
        bit in_access;
        forever begin
            @(negedge PCLK);
            completing = PRESETn && in_flight && !cur_to && (e + 1 == end_edge);
            in_access  = in_flight && (e > acc_edge);
            if (completing) begin
                PREADY  = 1'b1;
                PRDATA  = cur.rdata;
                PSLVERR = cur.err;
            end else begin
                PREADY  = in_access ? 1'b0 : 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end
    end

    // handshake sampled mid-cycle, after the drivers have settled
    initial begin
        forever begin
            @(negedge PCLK);
            #2;
            pre_v = cmd_valid;
            pre_r = cmd_ready;
        end
    end

    // per-cycle compare
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            if (PRESETn) begin
                if (pre_v && pre_r) begin
                    dut_acc_e = e;
                    if (dut_acc_cnt < 16) acc_hist[dut_acc_cnt] = e;
                    dut_acc_cnt++;
                end
                chk("cmd_ready",   64'(cmd_ready),   64'(!in_flight));
                chk("PSEL",        64'(PSEL),        64'(in_flight));
                chk("PENABLE",     64'(PENABLE),     64'(in_flight && (e > acc_edge)));
                chk("rsp_valid",   64'(rsp_valid),   64'(x_rsp_valid));
                chk("rsp_rdata",   64'(rsp_rdata),   64'(x_rdata));
                chk("rsp_err",     64'(rsp_err),     64'(x_err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(x_to));
                chk("PADDR",       64'(PADDR),       64'(x_paddr));
                chk("PWDATA",      64'(PWDATA),      64'(x_pwdata));
                chk("PWRITE",      64'(PWRITE),      64'(x_pwrite));
                if (rsp_valid) begin
                    rsp_cnt++;
                    last_lat   = e - dut_acc_e;
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    last_to    = rsp_timeout;
                end
            end
        end
    end

    task automatic drive_fields(input int idx);
        if (idx < NV) begin
            cmd_write = vec[idx].wr;
            cmd_addr  = vec[idx].addr;
            cmd_wdata = vec[idx].wdata;
        end
    endtask

    task automatic wait_rsp(input int target, input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            if (rsp_cnt >= target) break;
            @(negedge PCLK);
        end
        if (rsp_cnt < target) chk({name, "_rsp_wait"}, 64'(rsp_cnt), 64'(target));
    endtask

    // present vec[idx] until the model takes it, then wait for its response
    task automatic do_cmd(input int idx, input string name);
        int start;
        start = rsp_cnt;
        @(negedge PCLK);
        drive_fields(idx);
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            if (n_acc > idx) break;
        end
        cmd_valid = 1'b0;
        wait_rsp(start + 1, name);
    endtask

    initial begin
        int start;
        vec[0] = '{1'b1, 32'h000, 32'h0000_A5A5, 0,   1'b0, 32'h0};
        vec[1] = '{1'b0, 32'h004, 32'h0,         3,   1'b0, 32'h0000_1234};
        vec[2] = '{1'b0, 32'h008, 32'h0,         0,   1'b1, 32'hDEAD_BEEF};
        vec[3] = '{1'b0, 32'h010, 32'h0,         100, 1'b0, 32'h1111_2222};
        vec[4] = '{1'b1, 32'h014, 32'h5555_0000, 15,  1'b0, 32'h0};
        vec[5] = '{1'b1, 32'h020, 32'h0000_0001, 0,   1'b0, 32'h0};
        vec[6] = '{1'b0, 32'h024, 32'h0,         0,   1'b0, 32'hCAFE_0001};
        vec[7] = '{1'b1, 32'h028, 32'h0000_0003, 0,   1'b0, 32'h0};
        vec[8] = '{1'b1, 32'h030, 32'h7777_7777, 10,  1'b0, 32'h0};
        vec[9] = '{1'b0, 32'h034, 32'h0,         1,   1'b0, 32'h0BAD_F00D};

        // reset values
        repeat (2) @(negedge PCLK);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_PSEL",      64'(PSEL),      64'd0);
        chk("rst_PENABLE",   64'(PENABLE),   64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_PADDR",     64'(PADDR),     64'd0);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        do_cmd(0, "wr0");
        chk("wr0_lat",   64'(last_lat),   64'd2);
        chk("wr0_rdata", 64'(last_rdata), 64'd0);
        chk("wr0_err",   64'(last_err),   64'd0);

        do_cmd(1, "rd1");
        chk("rd1_lat",   64'(last_lat),   64'd5);
        chk("rd1_rdata", 64'(last_rdata), 64'h0000_1234);

        do_cmd(2, "rd2");
        chk("rd2_err",   64'(last_err),   64'd1);
        chk("rd2_to",    64'(last_to),    64'd0);
        chk("rd2_rdata", 64'(last_rdata), 64'hDEAD_BEEF);

        do_cmd(3, "to3");
        chk("to3_lat",   64'(last_lat),   64'd17);
        chk("to3_err",   64'(last_err),   64'd1);
        chk("to3_to",    64'(last_to),    64'd1);
        chk("to3_rdata", 64'(last_rdata), 64'd0);

        do_cmd(4, "wr4");
        chk("wr4_lat",   64'(last_lat),   64'd17);
        chk("wr4_err",   64'(last_err),   64'd0);
        chk("wr4_to",    64'(last_to),    64'd0);

        // back-to-back with cmd_valid held high
        start = rsp_cnt;
        @(negedge PCLK);
        drive_fields(n_acc);
        cmd_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (n_acc >= 8) break;
            drive_fields(n_acc);
        end
        cmd_valid = 1'b0;
        wait_rsp(start + 3, "b2b");
        chk("b2b_gap1",  64'(acc_hist[6] - acc_hist[5]), 64'd3);
        chk("b2b_gap2",  64'(acc_hist[7] - acc_hist[6]), 64'd3);
        chk("b2b_rdata", 64'(last_rdata), 64'd0);

        // reset in the middle of ACCESS of a write
        start = rsp_cnt;
        @(negedge PCLK);
        drive_fields(8);
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            if (n_acc > 8) break;
        end
        cmd_valid = 1'b0;
        repeat (3) @(posedge PCLK);
        #3;
        PRESETn = 1'b0;
        #1;
        chk("arst_PSEL",      64'(PSEL),      64'd0);
        chk("arst_PENABLE",   64'(PENABLE),   64'd0);
        chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (15) @(negedge PCLK);
        chk("arst_no_rsp", 64'(rsp_cnt), 64'(start));

        do_cmd(9, "rd9");
        chk("rd9_lat",   64'(last_lat),   64'd3);
        chk("rd9_rdata", 64'(last_rdata), 64'h0BAD_F00D);
        chk("rd9_err",   64'(last_err),   64'd0);

        repeat (3) @(negedge PCLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
